// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage arithmetic block.
//   - PC_WIDTH-bit PC incrementer (combinational, wraps modulo 2^PC_WIDTH)
//   - ALU-control decoder: ALUOp + funct -> 4-bit selector (combinational)
//   - WIDTH-bit ALU whose result and zero flag are registered (1-cycle latency)
// Optional build macro: ALU_OVF_EN adds a registered signed-overflow flag OF.
module alu_exec_unit #(
  parameter int WIDTH    = 32,
  parameter int PC_WIDTH = 8,
  parameter int PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] operando1,
  output logic [PC_WIDTH-1:0] resultado_add,
  input  logic [5:0]          Func,
  input  logic [2:0]          InOp,
  output logic [3:0]          outOp,
  input  logic [WIDTH-1:0]    operador1,
  input  logic [WIDTH-1:0]    operador2,
  output logic [WIDTH-1:0]    resultado,
  output logic                ZF
`ifdef ALU_OVF_EN
  ,
  output logic                OF
`endif
);

  // ALU selector encodings
  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_XOR = 4'b0011;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_SLT = 4'b0111;
  localparam logic [3:0] SEL_NOR = 4'b1100;

  // Incrementer constant truncated to the address width so the add wraps
  localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(PC_STEP);

  logic [3:0]       sel_next;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] diff_next;
  logic             slt_next;
  logic [WIDTH-1:0] result_next;
  logic [WIDTH-1:0] result_reg;
  logic             zf_reg;

  // PC + step; reset has no effect on this path
  assign resultado_add = operando1 + PC_INC;

  // Decode ALUOp, falling back to the funct field for R-type instructions
  always_comb begin
    sel_next = SEL_ADD;
    case (InOp)
      3'b000: sel_next = SEL_ADD;
      3'b001: sel_next = SEL_SUB;
      3'b010: begin
        case (Func)
          6'b100000: sel_next = SEL_ADD;
          6'b100010: sel_next = SEL_SUB;
          6'b100100: sel_next = SEL_AND;
          6'b100101: sel_next = SEL_OR;
          6'b100110: sel_next = SEL_XOR;
          6'b100111: sel_next = SEL_NOR;
          6'b101010: sel_next = SEL_SLT;
          default:   sel_next = SEL_ADD;
        endcase
      end
      3'b011: sel_next = SEL_AND;
      3'b100: sel_next = SEL_OR;
      3'b101: sel_next = SEL_SLT;
      default: sel_next = SEL_ADD;
    endcase
  end

  assign outOp = sel_next;

  // Shared adder/subtractor outputs; carry-out is intentionally dropped
  assign sum_next  = operador1 + operador2;
  assign diff_next = operador1 - operador2;
  assign slt_next  = $signed(operador1) < $signed(operador2);

  // Select the ALU function for the value captured on the next edge
  always_comb begin
    result_next = '0;
    case (sel_next)
      SEL_AND: result_next = operador1 & operador2;
      SEL_OR:  result_next = operador1 | operador2;
      SEL_ADD: result_next = sum_next;
      SEL_XOR: result_next = operador1 ^ operador2;
      SEL_SUB: result_next = diff_next;
      SEL_NOR: result_next = ~(operador1 | operador2);
      SEL_SLT: result_next = {{(WIDTH-1){1'b0}}, slt_next};
      default: result_next = '0;
    endcase
  end

  // Result and zero-flag register; async low reset leaves a zero result, ZF=1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_reg <= '0;
      zf_reg     <= 1'b1;
    end else begin
      result_reg <= result_next;
      zf_reg     <= (result_next == '0);
    end
  end

  assign resultado = result_reg;
  assign ZF        = zf_reg;

`ifdef ALU_OVF_EN
  logic of_next;
  logic of_reg;

  // Signed overflow only has meaning for ADD and SUB
  always_comb begin
    of_next = 1'b0;
    case (sel_next)
      SEL_ADD: of_next = (operador1[WIDTH-1] == operador2[WIDTH-1]) &&
                         (sum_next[WIDTH-1] != operador1[WIDTH-1]);
      SEL_SUB: of_next = (operador1[WIDTH-1] != operador2[WIDTH-1]) &&
                         (diff_next[WIDTH-1] != operador1[WIDTH-1]);
      default: of_next = 1'b0;
    endcase
  end

  // Overflow flag travels with the result register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      of_reg <= 1'b0;
    end else begin
      of_reg <= of_next;
    end
  end

  assign OF = of_reg;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed + random scoreboard bench for alu_exec_unit.
// Expected results are queued when an operation is driven and popped when
// the registered output appears one clock later.
module tb_alu_exec_unit;

  logic        clk;
  logic        reset;
  logic [7:0]  operando1;
  logic [7:0]  resultado_add;
  logic [5:0]  Func;
  logic [2:0]  InOp;
  logic [3:0]  outOp;
  logic [31:0] operador1;
  logic [31:0] operador2;
  logic [31:0] resultado;
  logic        ZF;
`ifdef ALU_OVF_EN
  logic        OF;
`endif

  alu_exec_unit #(.WIDTH(32), .PC_WIDTH(8), .PC_STEP(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .operando1     (operando1),
    .resultado_add (resultado_add),
    .Func          (Func),
    .InOp          (InOp),
    .outOp         (outOp),
    .operador1     (operador1),
    .operador2     (operador2),
    .resultado     (resultado),
    .ZF            (ZF)
`ifdef ALU_OVF_EN
    ,
    .OF            (OF)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        zf;
    logic        of;
  } exp_t;

  exp_t q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  // One comparison: counts it and reports a FAIL line on mismatch
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " res"}, resultado, 32'h0);
    check({tag, " zf"}, {31'h0, ZF}, 32'h1);
`ifdef ALU_OVF_EN
    check({tag, " of"}, {31'h0, OF}, 32'h0);
`endif
  endtask

  // Pop the oldest expectation and compare against the registered outputs
  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      check("scoreboard empty", 32'h1, 32'h0);
    end else begin
      e = q.pop_front();
      check({e.tag, " res"}, resultado, e.res);
      check({e.tag, " zf"}, {31'h0, ZF}, {31'h0, e.zf});
`ifdef ALU_OVF_EN
      check({e.tag, " of"}, {31'h0, OF}, {31'h0, e.of});
`endif
    end
  endtask

  // Drive one operation, check the decoder, then the result a clock later
  task automatic run_op(input string tag, input logic [2:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] exp_sel, input logic [31:0] exp_res,
                        input logic exp_of);
    exp_t e;
    InOp = op; Func = fn; operador1 = a; operador2 = b;
    #1;
    check({tag, " sel"}, {28'h0, outOp}, {28'h0, exp_sel});
    e.tag = tag; e.res = exp_res; e.zf = (exp_res == 32'h0); e.of = exp_of;
    q.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  // Reference decode used for randomized operations
  function automatic logic [3:0] m_sel(input logic [2:0] op, input logic [5:0] fn);
    case (op)
      3'b001: return 4'b0110;
      3'b011: return 4'b0000;
      3'b100: return 4'b0001;
      3'b101: return 4'b0111;
      3'b010: begin
        case (fn)
          6'b100010: return 4'b0110;
          6'b100100: return 4'b0000;
          6'b100101: return 4'b0001;
          6'b100110: return 4'b0011;
          6'b100111: return 4'b1100;
          6'b101010: return 4'b0111;
          default:   return 4'b0010;
        endcase
      end
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0110: return a - b;
      4'b1100: return ~(a | b);
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_of(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] wide;
    if (s == 4'b0010) begin
      wide = {a[31], a} + {b[31], b};
      return wide[32] != wide[31];
    end else if (s == 4'b0110) begin
      wide = {a[31], a} - {b[31], b};
      return wide[32] != wide[31];
    end
    return 1'b0;
  endfunction

  initial begin
    reset = 1'b0;
    operando1 = 8'd0;
    InOp = 3'b010; Func = 6'b100000;
    operador1 = 32'd5; operador2 = 32'd7;

    // Held in reset across several edges with a nonzero pending result
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset_state($sformatf("hold_reset%0d", i));
    end

    // Incrementer, including wrap
    #1; check("pc 0", {24'h0, resultado_add}, 32'd4);
    operando1 = 8'd252; #1; check("pc 252 wrap", {24'h0, resultado_add}, 32'd0);
    operando1 = 8'd100; #1; check("pc 100", {24'h0, resultado_add}, 32'd104);

    @(negedge clk);
    reset = 1'b1;

    // R-type arithmetic
    run_op("add 5+7",  3'b010, 6'b100000, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0);
    run_op("sub 7-7",  3'b010, 6'b100010, 32'd7, 32'd7, 4'b0110, 32'd0, 1'b0);
    run_op("sub 0-1",  3'b010, 6'b100010, 32'd0, 32'd1, 4'b0110, 32'hFFFF_FFFF, 1'b0);
    // Logic
    run_op("and", 3'b010, 6'b100100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'b0000, 32'h00F0_000F, 1'b0);
    run_op("or",  3'b010, 6'b100101, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'b0001, 32'hFFF0_0FFF, 1'b0);
    run_op("xor", 3'b010, 6'b100110, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'b0011, 32'hFF00_0FF0, 1'b0);
    run_op("nor", 3'b010, 6'b100111, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'b1100, 32'h000F_F000, 1'b0);
    // Signed SLT, R-type and slti
    run_op("slt -1<1",   3'b010, 6'b101010, 32'hFFFF_FFFF, 32'd1, 4'b0111, 32'd1, 1'b0);
    run_op("slt 1<-1",   3'b010, 6'b101010, 32'd1, 32'hFFFF_FFFF, 4'b0111, 32'd0, 1'b0);
    run_op("slti -1<1",  3'b101, 6'b000000, 32'hFFFF_FFFF, 32'd1, 4'b0111, 32'd1, 1'b0);
    run_op("slti 1<-1",  3'b101, 6'b000000, 32'd1, 32'hFFFF_FFFF, 4'b0111, 32'd0, 1'b0);
    // ALUOp overrides and defaults
    run_op("lw add ovr", 3'b000, 6'b100010, 32'd10, 32'd3, 4'b0010, 32'd13, 1'b0);
    run_op("beq equal",  3'b001, 6'b100000, 32'h1234, 32'h1234, 4'b0110, 32'd0, 1'b0);
    run_op("rtype fn0",  3'b010, 6'b000000, 32'd2, 32'd3, 4'b0010, 32'd5, 1'b0);
    run_op("andi",       3'b011, 6'b100000, 32'hFF, 32'h0F0, 4'b0000, 32'hF0, 1'b0);
    run_op("ori",        3'b100, 6'b100000, 32'h100, 32'h001, 4'b0001, 32'h101, 1'b0);
    run_op("op110 add",  3'b110, 6'b100111, 32'd1, 32'd1, 4'b0010, 32'd2, 1'b0);
    run_op("op111 add",  3'b111, 6'b101010, 32'd4, 32'd4, 4'b0010, 32'd8, 1'b0);
    // Overflow and carry-out discard
    run_op("add ovf",    3'b010, 6'b100000, 32'h7FFF_FFFF, 32'd1, 4'b0010, 32'h8000_0000, 1'b1);
    run_op("sub ovf",    3'b001, 6'b000000, 32'h8000_0000, 32'd1, 4'b0110, 32'h7FFF_FFFF, 1'b1);
    run_op("add carry",  3'b000, 6'b000000, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, 1'b0);

    // Randomized back-to-back operations against the reference functions
    for (int i = 0; i < 20; i++) begin
      logic [2:0]  op;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  s;
      op = 3'($urandom_range(0, 7));
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(6'b100000 + 6'($urandom_range(0, 10)));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? a : $urandom;
      s  = m_sel(op, fn);
      run_op($sformatf("rand%0d", i), op, fn, a, b, s, m_alu(s, a, b), m_of(s, a, b));
    end

    // Asynchronous reset between edges discards the pending operation
    run_op("pre-reset add", 3'b010, 6'b100000, 32'd20, 32'd22, 4'b0010, 32'd42, 1'b0);
    InOp = 3'b010; Func = 6'b100000; operador1 = 32'd9; operador2 = 32'd9;
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(posedge clk);
    #1;
    check_reset_state("async_reset_held");
    @(negedge clk);
    reset = 1'b1;
    check("scoreboard drained", q.size(), 32'd0);

    // First capture after reset release
    run_op("post-reset sub", 3'b010, 6'b100010, 32'd50, 32'd8, 4'b0110, 32'd42, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage arithmetic block for the single-cycle MIPS-style datapath. It contains three parts:
- An 8-bit PC+4 incrementer.
- An ALU-control decoder that maps the 3-bit ALUOp and the 6-bit funct field to a 4-bit ALU selector.
- A 32-bit ALU with a registered result and zero flag.

It sits between the register bank/ALUSrc mux and the data memory/write-back mux.

Parameters:
- WIDTH, 32, ALU datapath width.
- PC_WIDTH, 8, instruction-address width.
- PC_STEP, 4, incrementer constant.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- operando1  input  PC_WIDTH  current PC.
- resultado_add  output  PC_WIDTH  operando1+PC_STEP, combinational.
- Func  input  6  instruction funct field [5:0].
- InOp  input  3  ALUOp from control unit.
- outOp  output  4  decoded ALU selector, combinational.
- operador1  input  WIDTH  ALU operand A (register rs).
- operador2  input  WIDTH  ALU operand B (rt or immediate).
- resultado  output  WIDTH  registered ALU result.
- ZF  output  1  registered zero flag.

Behaviour:
- Incrementer:
  - resultado_add = operando1 + PC_STEP, modulo 2^PC_WIDTH.
  - Example wrap: 8'd252 -> 8'd0. Purely combinational; unaffected by reset.
- ALU control (combinational), InOp -> outOp:
  - 000 -> 0010 ADD (lw/sw/addi).
  - 001 -> 0110 SUB (beq).
  - 010 -> R-type, decode Func.
  - 011 -> 0000 AND (andi).
  - 100 -> 0001 OR (ori).
  - 101 -> 0111 SLT (slti).
  - 110, 111 -> 0010 ADD.
- R-type Func decode:
  - 100000 ADD 0010; 100010 SUB 0110; 100100 AND 0000; 100101 OR 0001.
  - 100110 XOR 0011; 100111 NOR 1100; 101010 SLT 0111.
  - Any other funct -> 0010 ADD.
- ALU selector functions (next-state computation, combinational):
  - 0000 A&B; 0001 A|B; 0010 A+B; 0011 A^B; 0110 A−B; 1100 ~(A|B).
  - 0111: 1 if signed(A) < signed(B), else 0, zero-extended.
  - Any other selector value: 0.
- Arithmetic is modulo 2^WIDTH; carry-out is discarded and signed overflow is ignored (unless the optional feature is enabled).
- Registers:
  - On each rising clk: resultado <= next result; ZF <= (next result == 0).
  - Latency is exactly 1 cycle from operands/Func/InOp to resultado/ZF. No handshake; a new operation is accepted every cycle.
- Reset:
  - reset low asynchronously forces resultado = 0 and ZF = 1, and holds them while low.
  - First capture occurs on the first rising clk after reset deasserts.
  - Reset asserted mid-operation discards the pending result.
- ZF is derived from the full WIDTH-bit result, including for SLT and for invalid selectors (invalid selector -> ZF=1).

Optional Feature:
- Macro ALU_OVF_EN.
- When defined:
  - Adds output port OF (1 bit, registered with resultado, reset value 0).
  - OF = 1 for signed overflow on ADD: operand signs equal and result sign differs.
  - OF = 1 for signed overflow on SUB: operand signs differ and result sign differs from A.
  - OF = 0 for all other selectors.
- When undefined: the OF port does not exist and overflow is silently ignored.

Test Plan:
- Reset/incrementer:
  - Hold reset=0 -> resultado=0, ZF=1 regardless of clk.
  - Release reset; operando1=8'd0 -> resultado_add=8'd4.
  - operando1=8'd252 -> resultado_add=8'd0.
- R-type arithmetic (InOp=010):
  - Func=100000, A=5, B=7 -> outOp=0010; after 1 clk resultado=12, ZF=0.
  - Func=100010, A=7, B=7 -> outOp=0110; resultado=0, ZF=1.
  - Func=100010, A=0, B=1 -> resultado=32'hFFFFFFFF.
- Logic (InOp=010), A=32'hF0F0_00FF, B=32'h0FF0_0F0F:
  - Func=100100 -> 32'h00F0_000F.
  - 100101 -> 32'hFFF0_0FFF.
  - 100110 -> 32'hFF00_0FF0.
  - 100111 -> 32'h000F_F000.
- SLT signed:
  - InOp=010, Func=101010, A=32'hFFFFFFFF (−1), B=1 -> resultado=1, ZF=0.
  - Swap operands -> resultado=0, ZF=1.
  - InOp=101 gives the same results.
- ALUOp overrides:
  - InOp=000 with Func=100010 -> outOp=0010 (ADD).
  - InOp=001, A=B=32'h1234 -> ZF=1 (beq taken).
  - InOp=010, Func=000000 -> outOp=0010.
- Overflow (with ALU_OVF_EN): ADD A=32'h7FFFFFFF, B=1 -> resultado=32'h80000000, OF=1.
- Asynchronous reset mid-stream: assert reset between clk edges -> resultado=0, ZF=1 immediately, without waiting for clk.
